// File: rtl/serial_cmp_pkg.sv
// Shared op codes, FSM states and result mapping for the multi-cycle comparator.
package serial_cmp_pkg;
  localparam int CMPOP_SIZE = 3;

  localparam logic [CMPOP_SIZE-1:0] CMPOP_EQ = 3'd0;
  localparam logic [CMPOP_SIZE-1:0] CMPOP_NE = 3'd1;
  localparam logic [CMPOP_SIZE-1:0] CMPOP_LT = 3'd2;
  localparam logic [CMPOP_SIZE-1:0] CMPOP_LE = 3'd3;
  localparam logic [CMPOP_SIZE-1:0] CMPOP_GT = 3'd4;
  localparam logic [CMPOP_SIZE-1:0] CMPOP_GE = 3'd5;

  typedef enum logic [1:0] {
    SCMP_IDLE = 2'd0,
    SCMP_SCAN = 2'd1,
    SCMP_DONE = 2'd2
  } scmp_state_e;

  // eq is implied when neither lt nor gt was seen by the end of the scan
  function automatic logic cmp_map(input logic [CMPOP_SIZE-1:0] op,
                                   input logic lt, input logic gt);
    logic eq;
    eq = ~(lt | gt);
    case (op)
      CMPOP_EQ: cmp_map = eq;
      CMPOP_NE: cmp_map = ~eq;
      CMPOP_LT: cmp_map = lt;
      CMPOP_LE: cmp_map = lt | eq;
      CMPOP_GT: cmp_map = gt;
      CMPOP_GE: cmp_map = gt | eq;
      default:  cmp_map = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/serial_cmp_slice.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module serial_cmp_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt,
  output logic             o_gt
);
  assign o_lt = (i_a < i_b);
  assign o_gt = (i_a > i_b);
endmodule

// File: rtl/serial_cmp.sv
// Multi-cycle relational comparator: scans MSB slice first, stops at first differing slice.
module serial_cmp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      operand1,
  input  logic [WIDTH-1:0]      operand2,
  input  logic [CMPOP_SIZE-1:0] operation,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic                  result
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_param
      $error("serial_cmp: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  scmp_state_e           r_state, w_nstate;
  logic [WIDTH-1:0]      r_op1, r_op2;
  logic [CMPOP_SIZE-1:0] r_op;
  logic [IDXW-1:0]       r_idx;
  logic                  r_result;
  logic                  w_load, w_inc, w_fin;
  logic                  w_lt, w_gt;

  // slice 0 is the most significant chunk
  logic [CHUNK-1:0] w_sl1 [NCHUNK];
  logic [CHUNK-1:0] w_sl2 [NCHUNK];
  for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
    assign w_sl1[g] = r_op1[WIDTH-1-g*CHUNK -: CHUNK];
    assign w_sl2[g] = r_op2[WIDTH-1-g*CHUNK -: CHUNK];
  end

  serial_cmp_slice #(.CHUNK(CHUNK)) u_slice (
    .i_a  (w_sl1[r_idx]),
    .i_b  (w_sl2[r_idx]),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    w_inc    = 1'b0;
    w_fin    = 1'b0;
    case (r_state)
      SCMP_IDLE: begin
        if (!flush && start) begin
          w_nstate = SCMP_SCAN;
          w_load   = 1'b1;
        end
      end
      SCMP_SCAN: begin
        if (flush) begin
          w_nstate = SCMP_IDLE;
        end else if (w_lt || w_gt || (r_idx == LAST)) begin
          w_nstate = SCMP_DONE;
          w_fin    = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      SCMP_DONE: begin
        if (!flush && start) begin
          w_nstate = SCMP_SCAN;
          w_load   = 1'b1;
        end else begin
          w_nstate = SCMP_IDLE;
        end
      end
      default: w_nstate = SCMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= SCMP_IDLE;
    else        r_state <= w_nstate;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_op     <= '0;
      r_idx    <= '0;
      r_result <= 1'b0;
    end else begin
      if (w_load) begin
        // flipping the sign bit turns two's-complement order into unsigned order
        r_op1            <= operand1;
        r_op1[WIDTH-1]   <= operand1[WIDTH-1] ^ is_signed;
        r_op2            <= operand2;
        r_op2[WIDTH-1]   <= operand2[WIDTH-1] ^ is_signed;
        r_op             <= operation;
        r_idx            <= '0;
      end else if (w_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_fin) r_result <= cmp_map(r_op, w_lt, w_gt);
    end
  end

  assign busy   = (r_state == SCMP_SCAN);
  assign done   = (r_state == SCMP_DONE);
  assign result = r_result;
endmodule

// File: tb/tb_serial_cmp.sv
// Directed bench for serial_cmp: 32/8 main instance plus a 64/16 instance.
module tb_serial_cmp;
  logic        clk, reset, start, flush, is_signed;
  logic [31:0] operand1, operand2;
  logic [2:0]  operation;
  logic        busy, done, result;

  logic        w_start, w_signed;
  logic [63:0] w_op1, w_op2;
  logic [2:0]  w_operation;
  logic        w_busy, w_done, w_result;

  int n_cmp = 0;
  int n_bad = 0;

  serial_cmp #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .operand1(operand1), .operand2(operand2), .operation(operation),
    .is_signed(is_signed), .busy(busy), .done(done), .result(result));

  serial_cmp #(.WIDTH(64), .CHUNK(16)) dut_w (
    .clk(clk), .reset(reset), .start(w_start), .flush(1'b0),
    .operand1(w_op1), .operand2(w_op2), .operation(w_operation),
    .is_signed(w_signed), .busy(w_busy), .done(w_done), .result(w_result));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // start in the current cycle (cycle 0); return the cycle where done is seen
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic s, output int cyc, output logic res, output logic b1);
    operand1 = a; operand2 = b; operation = op; is_signed = s; start = 1'b1;
    step(); start = 1'b0;
    b1 = busy; cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin step(); cyc++; end
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b0; step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (result !== 1'b0) begin n_bad++; $display("FAIL rst_result got %b want 0", result); end
    n_cmp++; if (w_busy !== 1'b0) begin n_bad++; $display("FAIL rst_w_busy got %b want 0", w_busy); end
    n_cmp++; if (w_done !== 1'b0) begin n_bad++; $display("FAIL rst_w_done got %b want 0", w_done); end
    n_cmp++; if (w_result !== 1'b0) begin n_bad++; $display("FAIL rst_w_result got %b want 0", w_result); end
    reset = 1'b1; step();
  endtask

  task automatic test_msb_diff();
    int c; logic r, b1;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b1, c, r, b1);
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL msb_s_busy1 got %b want 1", b1); end
    n_cmp++; if (c != 2) begin n_bad++; $display("FAIL msb_s_cycle got %0d want 2", c); end
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL msb_s_result got %b want 1", r); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL msb_s_busy_done got %b want 0", busy); end
    step();
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b0, c, r, b1);
    n_cmp++; if (c != 2) begin n_bad++; $display("FAIL msb_u_cycle got %0d want 2", c); end
    n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL msb_u_result got %b want 0", r); end
    step();
  endtask

  task automatic test_lsb_diff();
    int c; logic r, b1;
    run_op(32'h0000_0010, 32'h0000_0011, 3'd2, 1'b0, c, r, b1);
    n_cmp++; if (c != 5) begin n_bad++; $display("FAIL lsb_lt_cycle got %0d want 5", c); end
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL lsb_lt_result got %b want 1", r); end
    step();
    run_op(32'h0000_0010, 32'h0000_0011, 3'd5, 1'b0, c, r, b1);
    n_cmp++; if (c != 5) begin n_bad++; $display("FAIL lsb_ge_cycle got %0d want 5", c); end
    n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL lsb_ge_result got %b want 0", r); end
    step();
  endtask

  task automatic test_equal();
    logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    logic       exp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int c; logic r, b1;
    for (int i = 0; i < 7; i++) begin
      run_op(32'h1234_5678, 32'h1234_5678, ops[i], 1'b0, c, r, b1);
      n_cmp++; if (c != 5) begin n_bad++; $display("FAIL eq_cycle op%0d got %0d want 5", ops[i], c); end
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL eq_result op%0d got %b want %b", ops[i], r, exp[i]); end
      step();
    end
  endtask

  task automatic test_flush();
    int c; logic r, b1; logic saw_done;
    run_op(32'h1234_5678, 32'h1234_5678, 3'd0, 1'b0, c, r, b1);
    step();
    operand1 = 32'h10; operand2 = 32'h11; operation = 3'd5; is_signed = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", busy); end
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      step();
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL flush_no_done got %b want 0", saw_done); end
    n_cmp++; if (result !== 1'b1) begin n_bad++; $display("FAIL flush_result got %b want 1", result); end
    start = 1'b1; flush = 1'b1;
    step(); start = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_start_busy got %b want 0", busy); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_start_done got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int c;
    operand1 = 32'hFF00_0000; operand2 = 32'h0; operation = 3'd4; is_signed = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done got %b want 1", done); end
    n_cmp++; if (result !== 1'b1) begin n_bad++; $display("FAIL b2b_first_result got %b want 1", result); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_done_busy got %b want 0", busy); end
    operand1 = 32'h10; operand2 = 32'h11; operation = 3'd2; start = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_again got %b want 1", busy); end
    operand1 = 32'h5; operand2 = 32'h5; operation = 3'd1;
    step(); start = 1'b0;
    c = 2;
    while (done !== 1'b1 && c < 20) begin step(); c++; end
    n_cmp++; if (c != 5) begin n_bad++; $display("FAIL b2b_second_cycle got %0d want 5", c); end
    n_cmp++; if (result !== 1'b1) begin n_bad++; $display("FAIL b2b_second_result got %b want 1", result); end
    step();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_not_queued got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid();
    operand1 = 32'h1234_5678; operand2 = 32'h1234_5678; operation = 3'd1; is_signed = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    reset = 1'b0;
    step(); reset = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done got %b want 0", done); end
    n_cmp++; if (result !== 1'b0) begin n_bad++; $display("FAIL rmid_result got %b want 0", result); end
    step();
  endtask

  task automatic test_wide();
    int c;
    w_op1 = 64'h8000_0000_0000_0000; w_op2 = 64'h0; w_operation = 3'd2; w_signed = 1'b1; w_start = 1'b1;
    step(); w_start = 1'b0;
    c = 1;
    while (w_done !== 1'b1 && c < 20) begin step(); c++; end
    n_cmp++; if (c != 2) begin n_bad++; $display("FAIL wide_s_cycle got %0d want 2", c); end
    n_cmp++; if (w_result !== 1'b1) begin n_bad++; $display("FAIL wide_s_result got %b want 1", w_result); end
    step();
    w_signed = 1'b0; w_start = 1'b1;
    step(); w_start = 1'b0;
    c = 1;
    while (w_done !== 1'b1 && c < 20) begin step(); c++; end
    n_cmp++; if (c != 2) begin n_bad++; $display("FAIL wide_u_cycle got %0d want 2", c); end
    n_cmp++; if (w_result !== 1'b0) begin n_bad++; $display("FAIL wide_u_result got %b want 0", w_result); end
    step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    operand1 = '0; operand2 = '0; operation = '0;
    w_start = 1'b0; w_signed = 1'b0; w_op1 = '0; w_op2 = '0; w_operation = '0;
    #1;
    test_reset();
    test_msb_diff();
    test_lsb_diff();
    test_equal();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
